// File: rtl/expand3_seq_pkg.sv
// Shared types and default sizes for the 3x3 expand-layer weight sequencer.
package expand3_seq_pkg;

  localparam int KK         = 9;           // taps per input channel (3x3 kernel)
  localparam int IN_CH      = 64;          // input channels
  localparam int DEPTH      = IN_CH * KK;  // ROM words per output pixel
  localparam int ROM1_DEPTH = 512;         // first physical ROM holds words 0..511

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/expand3_weight_seq_mod_counter.sv
// Modulo-MOD up counter with enable, synchronous clear and a wrap flag.
// o_wrap is high in the cycle where an enabled count rolls MOD-1 -> 0, so
// counters can be chained by feeding one stage's o_wrap into the next i_en.
module mod_counter #(
  parameter int MOD = 9,
  parameter int W   = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt,
  output logic         o_wrap
);

  logic [W-1:0] r_cnt;

  assign o_wrap = i_en && (r_cnt == W'(MOD - 1));
  assign o_cnt  = r_cnt;

  // Count register: clear has priority over enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_wrap ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/expand3_weight_seq.sv
// Weight-beat sequencer for the 3x3 expand layer. For every output pixel it
// walks the weight ROM in channel-major order (addr = ch*KK + k) using
// chained counters plus an incrementing address register, so no multiplier
// is needed. Beats follow valid/ready: a beat transfers when w_valid and
// w_ready are both high at a rising edge; while w_valid=1 and w_ready=0 the
// beat (address, indices, first/last flags) is held unchanged.
module expand3_weight_seq #(
  parameter  int ADDR   = 10,
  parameter  int KK     = expand3_seq_pkg::KK,
  parameter  int IN_CH  = expand3_seq_pkg::IN_CH,
  parameter  int PIXELS = 196,
  localparam int CH_W   = $clog2(IN_CH),
  localparam int PIX_W  = $clog2(PIXELS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             w_ready,
  output logic [ADDR-1:0]  rom_addr,
  output logic             w_valid,
  output logic [3:0]       k_idx,
  output logic [CH_W-1:0]  ch_idx,
  output logic [PIX_W-1:0] pix_idx,
  output logic             acc_first,
  output logic             acc_last,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  import expand3_seq_pkg::state_t, expand3_seq_pkg::ST_IDLE,
         expand3_seq_pkg::ST_RUN, expand3_seq_pkg::ST_DONE;

  localparam int DEPTH = IN_CH * KK;

  state_t          r_state;
  state_t          w_next_state;
  logic [ADDR-1:0] r_addr;
  logic            r_first;
  logic            r_last;

  logic             w_start_go;
  logic             w_xfer;
  logic             w_k_wrap;
  logic             w_ch_wrap;
  logic             w_pix_wrap;
  logic [3:0]       w_k_cnt;
  logic [CH_W-1:0]  w_ch_cnt;
  logic [PIX_W-1:0] w_pix_cnt;

  assign w_start_go = (r_state == ST_IDLE) && start;
  assign w_xfer     = (r_state == ST_RUN) && w_ready;

  // Tap counter advances on every transferred beat.
  mod_counter #(.MOD(KK), .W(4)) u_k_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_xfer),
    .i_clr  (w_start_go),
    .o_cnt  (w_k_cnt),
    .o_wrap (w_k_wrap)
  );

  // Channel counter advances when the tap counter wraps.
  mod_counter #(.MOD(IN_CH), .W(CH_W)) u_ch_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_k_wrap),
    .i_clr  (w_start_go),
    .o_cnt  (w_ch_cnt),
    .o_wrap (w_ch_wrap)
  );

  // Pixel counter advances when the channel counter wraps; its wrap marks
  // the final beat of the run.
  mod_counter #(.MOD(PIXELS), .W(PIX_W)) u_pix_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_ch_wrap),
    .i_clr  (w_start_go),
    .o_cnt  (w_pix_cnt),
    .o_wrap (w_pix_wrap)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: start only matters in IDLE, DONE lasts one cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (start)      w_next_state = ST_RUN;
      ST_RUN:  if (w_pix_wrap) w_next_state = ST_DONE;
      ST_DONE:                 w_next_state = ST_IDLE;
      default:                 w_next_state = ST_IDLE;
    endcase
  end

  // ROM address and accumulator flags: address restarts at 0 on every
  // channel wrap, so it never passes DEPTH-1 and crosses the 511->512 ROM
  // split as an ordinary increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
    end else if (w_start_go) begin
      r_addr  <= '0;
      r_first <= 1'b1;
      r_last  <= (DEPTH == 1);
    end else if (w_xfer) begin
      if (w_pix_wrap) begin
        r_addr  <= '0;
        r_first <= 1'b0;
        r_last  <= 1'b0;
      end else if (w_ch_wrap) begin
        r_addr  <= '0;
        r_first <= 1'b1;
        r_last  <= (DEPTH == 1);
      end else begin
        r_addr  <= r_addr + 1'b1;
        r_first <= 1'b0;
        r_last  <= (r_addr == ADDR'(DEPTH - 2));
      end
    end
  end

  assign rom_addr  = r_addr;
  assign acc_first = r_first;
  assign acc_last  = r_last;
  assign k_idx     = w_k_cnt;
  assign ch_idx    = w_ch_cnt;
  assign pix_idx   = w_pix_cnt;
  assign w_valid   = (r_state == ST_RUN);
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_expand3_weight_seq.sv
// Bench for expand3_weight_seq, built with PIXELS=12 so full runs stay short.
// Expected beats come from a queue filled from the addressing rule
// (addr = n mod DEPTH, k = addr mod KK, ch = addr / KK, pix = n / DEPTH).
module tb_expand3_weight_seq;

  localparam int ADDR   = 10;
  localparam int KK     = 9;
  localparam int IN_CH  = 64;
  localparam int PIXELS = 12;
  localparam int DEPTH  = IN_CH * KK;
  localparam int CH_W   = $clog2(IN_CH);
  localparam int PIX_W  = $clog2(PIXELS);
  localparam int BW     = PIX_W + CH_W + 4 + 2 + ADDR;
  localparam int LIMIT  = 40000;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst;
  logic start;
  logic w_ready;
  logic [ADDR-1:0]  rom_addr;
  logic             w_valid;
  logic [3:0]       k_idx;
  logic [CH_W-1:0]  ch_idx;
  logic [PIX_W-1:0] pix_idx;
  logic             acc_first;
  logic             acc_last;
  logic             busy;
  logic             done;
  logic [1:0]       dbg_state;

  always #5 clk = ~clk;

  expand3_weight_seq #(
    .ADDR(ADDR), .KK(KK), .IN_CH(IN_CH), .PIXELS(PIXELS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .w_ready   (w_ready),
    .rom_addr  (rom_addr),
    .w_valid   (w_valid),
    .k_idx     (k_idx),
    .ch_idx    (ch_idx),
    .pix_idx   (pix_idx),
    .acc_first (acc_first),
    .acc_last  (acc_last),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  logic [BW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      $error("check %s differs", tag);
    end
  endtask

  function automatic logic [BW-1:0] act_beat();
    return {pix_idx, ch_idx, k_idx, acc_first, acc_last, rom_addr};
  endfunction

  function automatic logic [31:0] all_outs();
    return {18'd0, w_valid, busy, done, acc_first, acc_last, dbg_state,
            pix_idx, ch_idx, k_idx, rom_addr} == '0 ? 32'd0 :
           {w_valid, busy, done, acc_first, acc_last, dbg_state,
            pix_idx[3:0], ch_idx[5:0], k_idx, rom_addr};
  endfunction

  // Expected beat stream of one full run.
  task automatic fill_q();
    logic [BW-1:0] e;
    int a;
    exp_q.delete();
    for (int n = 0; n < PIXELS * DEPTH; n++) begin
      a = n % DEPTH;
      e = {PIX_W'(n / DEPTH), CH_W'(a / KK), 4'(a % KK),
           (a == 0), (a == DEPTH - 1), ADDR'(a)};
      exp_q.push_back(e);
    end
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge: drive inputs, score a beat if it will
  // transfer at the coming rising edge, then advance to the next falling edge.
  task automatic cycle(input logic rdy, input logic st);
    w_ready = rdy;
    start   = st;
    if (w_valid === 1'b1 && rdy) begin
      if (exp_q.size() == 0) check("extra_beat", 32'(exp_q.size()), 32'd1);
      else check("beat", 32'(act_beat()), 32'(exp_q.pop_front()));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input bit rnd, input bit stall, input bit poke, input bit abort);
    int   cyc;
    int   beats;
    int   done_seen;
    bit   stalled;
    bit   poked;
    bit   saw_done;
    logic rdy;
    logic st;
    cyc = 0; beats = 0; done_seen = 0;
    stalled = 0; poked = 0; saw_done = 0;
    fill_q();
    cycle(1'b1, 1'b1);
    check("start_beat", {w_valid, acc_first, acc_last, busy, 18'd0, rom_addr},
          {1'b1, 1'b1, 1'b0, 1'b1, 18'd0, 10'd0});
    check("start_idx", {pix_idx, ch_idx, k_idx}, 32'd0);
    while (!saw_done && cyc < LIMIT) begin
      cyc++;
      if (done === 1'b1) begin
        saw_done = 1;
        done_seen++;
        check("done_state", {busy, w_valid}, {1'b1, 1'b0});
        break;
      end
      if (abort && w_valid === 1'b1 && pix_idx == 10 && rom_addr == 300) begin
        rst = 1'b1;
        #1;
        check("async_reset", all_outs(), 32'd0);
        @(negedge clk);
        check("reset_hold", all_outs(), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
          cycle(1'b1, 1'b0);
          check("post_reset_idle", {w_valid, busy}, 32'd0);
        end
        exp_q.delete();
        return;
      end
      if (stall && !stalled && w_valid === 1'b1 && pix_idx == 0 && rom_addr == 511) begin
        stalled = 1;
        for (int i = 0; i < 5; i++) begin
          cycle(1'b0, 1'b0);
          check("stall_hold", {w_valid, acc_first, acc_last, ch_idx, k_idx, rom_addr},
                {1'b1, 1'b0, 1'b0, 6'd56, 4'd7, 10'd511});
        end
        cycle(1'b1, 1'b0);
        beats++;
        check("after_stall", {w_valid, k_idx, rom_addr}, {1'b1, 4'd8, 10'd512});
        continue;
      end
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      st  = 1'b0;
      if (poke && !poked && beats == 100) begin
        st = 1'b1;
        poked = 1;
      end
      if (w_valid === 1'b1 && rdy) beats++;
      cycle(rdy, st);
    end
    check("run_finished", 32'(saw_done), 32'd1);
    check("beat_total", beats, PIXELS * DEPTH);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0);
      if (done === 1'b1) done_seen++;
    end
    check("done_pulses", done_seen, 1);
    check("idle_after_run", all_outs(), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; start = 1'b0; w_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_outs", all_outs(), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0);
      check("idle_no_beat", {w_valid, busy, done}, 32'd0);
    end
    // Full-rate run with a stall at 511 and an ignored start at beat 100.
    run(1'b0, 1'b1, 1'b1, 1'b0);
    // Run aborted by reset at pixel 10, address 300.
    run(1'b0, 1'b0, 1'b0, 1'b1);
    // Fresh run with random back-pressure.
    run(1'b1, 1'b0, 1'b0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
